// File: rtl/tty_uart_tx.sv
// Character FIFO feeding an 8N1 serial transmitter for the processor TTY port.
// Latency: a push into an empty FIFO is popped one edge later; the start bit appears on uart_tx one edge after the pop.
// Backpressure: TTY_ready drops when the FIFO is full; a write while full is dropped and latches overflow.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous active-low reset
//   TTY_data   - 7-bit ASCII character; TTY_en strobes it into the FIFO
//   TTY_clear  - flushes the FIFO and clears overflow; a frame on the line finishes
//   TTY_ready  - a write this cycle will be accepted
//   uart_tx    - registered serial output, idle high
//   busy       - frame on the line or characters still queued
//   overflow   - sticky: at least one write was dropped since the last clear/reset
module tty_uart_tx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] TTY_data,
  input  logic       TTY_en,
  input  logic       TTY_clear,
  output logic       TTY_ready,
  output logic       uart_tx,
  output logic       busy,
  output logic       overflow
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            ovf_q, ovf_d;
  logic [6:0]      mem_q [DEPTH];

  logic            push;
  logic            pop;
  logic            baud_done;

  assign TTY_ready = (count_q != FULL);
  assign uart_tx   = tx_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != IDLE) || (count_q != '0);
  assign baud_done = (baud_q == BAUD_LAST);

  // Clear beats a same-cycle write; the IDLE pop is independent of clear so
  // the head character still goes out while the rest is flushed.
  assign push = TTY_en && TTY_ready && !TTY_clear;
  assign pop  = (state_q == IDLE) && (count_q != '0);

  // FIFO bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (TTY_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      // Readiness is judged on the registered count, so a pop in the same
      // cycle as a full-FIFO write does not rescue the write.
      if (TTY_en && !TTY_ready) ovf_d = 1'b1;
    end
  end

  // Transmitter: tx_d is the line level for the current state, registered so
  // uart_tx trails the state register by one cycle.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d = {1'b0, mem_q[rd_ptr_q]};
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_done) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_done) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only read after being written, and
  // reset empties the FIFO through the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= TTY_data;
  end

endmodule

// File: doc/tty_uart_tx.md
TTY_UART_TX -- requirements
Module: tty_uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have parameter DEPTH, default 8, FIFO entries; power of 2, minimum 2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port TTY_data  input  7  ASCII character from the processor IO block.
REQ-007 SHALL have port TTY_en  input  1  write strobe, one character per cycle high.
REQ-008 SHALL have port TTY_clear  input  1  flush request.
REQ-009 SHALL have port TTY_ready  output  1  high when a write will be accepted.
REQ-010 SHALL have port uart_tx  output  1  serial line, idle high.
REQ-011 SHALL have port busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-012 SHALL have port overflow  output  1  sticky flag: a write was dropped.

Function
REQ-013 SHALL compute DIV = CLK_HZ/BAUD (integer division); each serial bit SHALL last exactly DIV clk cycles.
REQ-014 SHALL hold characters in a DEPTH-entry FIFO: read/write pointers wrap modulo DEPTH; count 0..DEPTH.
REQ-015 SHALL drive TTY_ready = (count != DEPTH), decoded from registered count only.
REQ-016 SHALL push TTY_data at the edge where TTY_en=1 and TTY_ready=1.
REQ-017 SHALL drop the character and set overflow at the edge where TTY_en=1 and TTY_ready=0.
REQ-018 Full FIFO plus simultaneous pop SHALL still reject that cycle's write (ready was 0); overflow set.
REQ-019 Simultaneous push and pop at 0<count<DEPTH SHALL leave count unchanged.
REQ-020 SHALL run transmitter FSM states IDLE, START, DATA, STOP.
REQ-021 IDLE: uart_tx=1; if count>0, pop head into shift register at that edge and go to START.
REQ-022 START: uart_tx=0 for DIV cycles, then DATA.
REQ-023 DATA: send 8 bits LSB first, byte = {1'b0, char}; bit counter 0..7; after bit 7 go to STOP.
REQ-024 STOP: uart_tx=1 for DIV cycles, then IDLE; the next character's pop may occur on the IDLE cycle, so frame gap is 1 cycle.
REQ-025 Latency: character pushed into empty FIFO with FSM IDLE at edge N; popped at edge N+1; uart_tx falls after edge N+2.
REQ-026 SHALL register uart_tx directly (no combinational glitch path).
REQ-027 TTY_clear=1 at an edge SHALL empty the FIFO (pointers and count to 0) and clear overflow.
REQ-028 A frame in progress when TTY_clear asserts SHALL complete unmodified.
REQ-029 TTY_clear and TTY_en in the same cycle: clear wins, the character is discarded, overflow not set.
REQ-030 TTY_clear in the same cycle as an IDLE pop: the pop SHALL proceed and that frame is sent; remaining entries are flushed.
REQ-031 busy = (state != IDLE) or (count != 0).

Reset
REQ-032 On reset=0, asynchronously: state IDLE, pointers/count/bit counter/baud counter 0, uart_tx=1, TTY_ready=1, busy=0, overflow=0.
REQ-033 Reset mid-frame SHALL abort the frame immediately, discard FIFO contents, and force uart_tx=1.
REQ-034 After reset release, the first write SHALL be accepted on the first rising edge with reset=1.

Verification (bench uses CLK_HZ=16, BAUD=1, so DIV=16; DEPTH=8)
REQ-035 Write 'A' (7'h41) to idle block -> uart_tx low at cycle 2 for 16 cycles, then bits 1,0,0,0,0,0,1,0 at 16 cycles each, then high 16 cycles; busy falls after 160+2 cycles.
REQ-036 Write 9 chars back-to-back -> first popped, next 8 fill FIFO; TTY_ready=0 with count=8; a 10th write with pop the same cycle is dropped and sets overflow=1.
REQ-037 Assert TTY_clear mid-DATA of frame 1 with 3 queued -> frame 1 completes intact; no further start bit; overflow=0; busy falls at frame-1 STOP end.
REQ-038 TTY_clear and TTY_en same cycle with FIFO empty, FSM IDLE -> count stays 0; uart_tx stays 1; overflow=0.
REQ-039 Pull reset low at bit 3 of a frame with 2 queued -> uart_tx=1 immediately; busy=0; TTY_ready=1; after release, write 7'h30 -> clean frame.
REQ-040 Push 20 chars, spaced to keep count<8 -> all 20 emitted in order; pointer wrap (past index 7) loses no data.
